shiftreg_sipo: RTL and testbench
================================

SHIFTREG_SIPO -- requirements
Module: shiftreg_sipo

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning word length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  clock qualifier for start and shifting.
REQ-005 SHALL have port clr  input  1  synchronous clear of capture state and flags; not gated by en.
REQ-006 SHALL have port start  input  1  begin a new word capture; sampled only when en=1.
REQ-007 SHALL have port bit_i  input  1  serial data, LSB first.
REQ-008 SHALL have port ack_i  input  1  consumer accepts word_o; not gated by en.
REQ-009 SHALL have port word_o  output  WIDTH  last completed word, registered.
REQ-010 SHALL have port valid_o  output  1  word_o holds an unacknowledged word.
REQ-011 SHALL have port busy_o  output  1  capture in progress.
REQ-012 SHALL have port ovr_o  output  1  sticky overrun flag.

Function
REQ-013 SHALL implement states IDLE and SHIFT, with busy_o=1 exactly in SHIFT.
REQ-014 SHALL keep an internal WIDTH-bit shift register sreg and a bit counter cnt of ceil(log2(WIDTH)) bits.
REQ-015 SHALL apply per-edge priority: rst > clr > start > shift; ack handling is independent of start and shift.
REQ-016 SHALL, on clr=1: state IDLE, cnt=0, sreg=0, word_o=0, valid_o=0, ovr_o=0; ack_i and bit_i ignored that cycle.
REQ-017 SHALL, on en=1 and start=1 in either state: state SHIFT, cnt=0, sreg=0, no bit sampled that cycle (start mid-word aborts and restarts).
REQ-018 SHALL, in SHIFT with en=1 and start=0: sreg <= {bit_i, sreg[WIDTH-1:1]}, cnt <= cnt+1.
REQ-019 SHALL, when the shift in REQ-018 occurs with cnt=WIDTH-1, load word_o <= {bit_i, sreg[WIDTH-1:1]}, set valid_o=1, go to IDLE, cnt=0; word_o valid on the edge after the WIDTH-th sampled bit.
REQ-020 SHALL hold state, cnt and sreg unchanged when en=0, and ignore bit_i in IDLE.
REQ-021 SHALL clear valid_o on a cycle with ack_i=1 and valid_o=1, unless a completion occurs on the same edge.
REQ-022 SHALL, on completion with ack_i=1 on the same edge, leave valid_o=1 with the new word and not set ovr_o.
REQ-023 SHALL, on completion while valid_o=1 and ack_i=0, overwrite word_o with the new word, keep valid_o=1, and set ovr_o=1.
REQ-024 SHALL keep ovr_o set until clr or rst.
REQ-025 SHALL have no effect from ack_i when valid_o=0.

Reset
REQ-026 SHALL, while rst=1 regardless of clk, force state IDLE, cnt=0, sreg=0, word_o=0, valid_o=0, busy_o=0, ovr_o=0.
REQ-027 SHALL, on rst asserted mid-word, discard the partial word; after release, wait for a new start.

Verification
REQ-028 SHALL check reset: rst pulse mid-word -> all outputs 0 immediately; following bits ignored until start.
REQ-029 SHALL check a basic word: WIDTH=10, en=1, start, then bits of 0x2A5 LSB first over 10 cycles -> busy_o=1 during shifting; after 10th edge word_o=0x2A5, valid_o=1, busy_o=0.
REQ-030 SHALL check en gating: same stream with en=0 on alternate cycles and garbage bit_i on en=0 cycles -> word_o=0x2A5 after 20 cycles.
REQ-031 SHALL check overrun: capture 0x155 with no ack, then capture 0x0F0 -> word_o=0x0F0, valid_o=1, ovr_o=1; clr -> all outputs 0.
REQ-032 SHALL check ack collision: ack_i=1 on the completion edge of 0x3FF while valid_o=1 -> word_o=0x3FF, valid_o=1, ovr_o=0.
REQ-033 SHALL check restart: start, 4 bits of 1, start again, then 10 bits of 0x001 -> word_o=0x001; clr after 5 bits -> busy_o=0, no valid_o.

Source files
------------

// File: rtl/shiftreg_sipo.sv
// Serial-in, parallel-out word capture.
// A capture is started with start, after which WIDTH bits are shifted in LSB
// first while en is high. The finished word is handed off on word_o with a
// valid/ack handshake. A sticky overrun flag records any unacknowledged word
// that was overwritten.
module shiftreg_sipo #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             start,
   input  logic             bit_i,
   input  logic             ack_i,
   output logic [WIDTH-1:0] word_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             ovr_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sreg;

   logic [WIDTH-1:0] next_sreg;
   logic             shift_en;
   logic             complete;

   // Decode whether this edge shifts a bit in and whether it finishes the word
   always_comb begin
      next_sreg = {bit_i, sreg[WIDTH-1:1]};
      shift_en  = (state == SHIFT) && en && !start;
      complete  = shift_en && (cnt == LAST_CNT);
   end

   // Capture FSM, shift register, output word and handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy_o  <= 1'b0;
         cnt     <= '0;
         sreg    <= '0;
         word_o  <= '0;
         valid_o <= 1'b0;
         ovr_o   <= 1'b0;
      end else if (clr) begin
         state   <= IDLE;
         busy_o  <= 1'b0;
         cnt     <= '0;
         sreg    <= '0;
         word_o  <= '0;
         valid_o <= 1'b0;
         ovr_o   <= 1'b0;
      end else begin
         if (en && start) begin
            state  <= SHIFT;
            busy_o <= 1'b1;
            cnt    <= '0;
            sreg   <= '0;
         end else if (shift_en) begin
            sreg <= next_sreg;
            if (complete) begin
               word_o <= next_sreg;
               state  <= IDLE;
               busy_o <= 1'b0;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         if (complete) begin
            valid_o <= 1'b1;
            if (valid_o && !ack_i) begin
               ovr_o <= 1'b1;
            end
         end else if (ack_i && valid_o) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shiftreg_sipo.sv
// Directed bench for shiftreg_sipo with WIDTH=10: reset, basic capture,
// en gating, overrun, ack collision and restart/clear behaviour.
module tb_shiftreg_sipo;

   localparam int WIDTH = 10;

   logic             clk;
   logic             rst;
   logic             en;
   logic             clr;
   logic             start;
   logic             bit_i;
   logic             ack_i;
   logic [WIDTH-1:0] word_o;
   logic             valid_o;
   logic             busy_o;
   logic             ovr_o;

   int checks   = 0;
   int failures = 0;

   shiftreg_sipo #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .start   (start),
      .bit_i   (bit_i),
      .ack_i   (ack_i),
      .word_o  (word_o),
      .valid_o (valid_o),
      .busy_o  (busy_o),
      .ovr_o   (ovr_o)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, return just after the rising edge
   task automatic applyStimulus(input logic e, input logic s, input logic b,
                                input logic a, input logic c);
      @(negedge clk);
      en    = e;
      start = s;
      bit_i = b;
      ack_i = a;
      clr   = c;
      @(posedge clk);
      #1;
   endtask

   // Start a capture and shift a full word in LSB first, ack only on the last bit
   task automatic sendWord(input logic [WIDTH-1:0] value, input logic ack_last);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < WIDTH; i++) begin
         applyStimulus(1'b1, 1'b0, value[i], (i == WIDTH - 1) ? ack_last : 1'b0, 1'b0);
      end
   endtask

   task automatic checkAll(input string tag, input logic [WIDTH-1:0] w,
                           input logic v, input logic b, input logic o);
      checkOutput({tag, "_word"},  32'(word_o),  32'(w));
      checkOutput({tag, "_valid"}, 32'(valid_o), 32'(v));
      checkOutput({tag, "_busy"},  32'(busy_o),  32'(b));
      checkOutput({tag, "_ovr"},   32'(ovr_o),   32'(o));
   endtask

   // Directed test sequence
   initial begin
      logic [WIDTH-1:0] pat;
      en    = 1'b0;
      start = 1'b0;
      bit_i = 1'b0;
      ack_i = 1'b0;
      clr   = 1'b0;
      rst   = 1'b1;
      #12;
      checkAll("reset", 10'h000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Reset mid-word clears everything at once, later bits are ignored
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("midword_busy", 32'(busy_o), 32'd1);
      #2 rst = 1'b1;
      #1 checkAll("async_rst", 10'h000, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkAll("post_rst_idle", 10'h000, 1'b0, 1'b0, 1'b0);

      // Basic word 0x2A5
      pat = 10'h2A5;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("basic_busy_start", 32'(busy_o), 32'd1);
      for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b1, 1'b0, pat[i], 1'b0, 1'b0);
      checkOutput("basic_busy_9", 32'(busy_o), 32'd1);
      checkOutput("basic_valid_9", 32'(valid_o), 32'd0);
      applyStimulus(1'b1, 1'b0, pat[WIDTH-1], 1'b0, 1'b0);
      checkAll("basic_done", 10'h2A5, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkAll("basic_ack", 10'h2A5, 1'b0, 1'b0, 1'b0);

      // en gating: garbage bits and start on en=0 cycles have no effect
      pat = 10'h2A5;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < WIDTH; i++) begin
         applyStimulus(1'b1, 1'b0, pat[i], 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b1, ~pat[i], 1'b0, 1'b0);
      end
      checkAll("engate_done", 10'h2A5, 1'b1, 1'b0, 1'b0);

      // Overrun: second word overwrites an unacknowledged one
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkAll("clr1", 10'h000, 1'b0, 1'b0, 1'b0);
      sendWord(10'h155, 1'b0);
      checkAll("ovr_first", 10'h155, 1'b1, 1'b0, 1'b0);
      sendWord(10'h0F0, 1'b0);
      checkAll("ovr_second", 10'h0F0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("ovr_sticky", 32'(ovr_o), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkAll("ovr_clr", 10'h000, 1'b0, 1'b0, 1'b0);

      // Ack on the completion edge keeps valid with the new word, no overrun
      sendWord(10'h155, 1'b0);
      sendWord(10'h3FF, 1'b1);
      checkAll("ack_collide", 10'h3FF, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("ack_clear_valid", 32'(valid_o), 32'd0);

      // Restart mid-word discards the partial word
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      sendWord(10'h001, 1'b0);
      checkAll("restart", 10'h001, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // clr mid-word aborts the capture, later bits ignored in IDLE
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      checkAll("clr_midword", 10'h000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkAll("idle_ignore", 10'h000, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
